// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end: FSM state, buffered entry and JAL decode.
// fetch_jal_offset is only used when FETCH_JAL_PREDICT_EN is defined.
package fetch_pkg;

    typedef enum logic [1:0] {
        StIssue,
        StWait,
        StDrop
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [6:0] OPC_JAL = 7'b1101111;

    // J-type immediate, sign-extended byte offset.
    function automatic logic [31:0] fetch_jal_offset(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous decode buffer of fetch entries with push/pop/flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  fetch_entry_t               wdata_i,
    output fetch_entry_t               rdata_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    fetch_entry_t            mem_q [DEPTH];
    logic [PtrW-1:0]         wr_ptr_q;
    logic [PtrW-1:0]         rd_ptr_q;
    logic [CntW-1:0]         count_q;
    logic                    do_push;
    logic                    do_pop;

    // Guards keep the buffer consistent even if a caller misbehaves.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q < CntW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC, single-outstanding cache request FSM and decode buffer.
// Define FETCH_JAL_PREDICT_EN to follow JAL targets on fetch instead of falling through.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ic_addr,
    output logic        ic_send_pulse,
    input  logic [31:0] ic_inst,
    input  logic        ic_ack,
    output logic        dec_valid,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    input  logic        dec_ready
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t        state_q, state_d;
    logic [31:0]         pc_q, pc_d;
    logic [31:0]         inflight_q, inflight_d;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_flush;
    logic                fifo_empty;
    logic [CntW-1:0]     fifo_count;
    fetch_entry_t        fifo_head;
    fetch_entry_t        fifo_wdata;

    logic                has_room;
    logic [31:0]         redir_pc;
    logic [31:0]         seq_pc;

    assign redir_pc  = {redirect_pc[31:2], 2'b00};
    assign fifo_pop  = dec_valid && dec_ready;
    // A pop this cycle frees the slot the upcoming ack will fill.
    assign has_room  = (fifo_count < CntW'(FIFO_DEPTH)) || fifo_pop;
    assign fifo_wdata = '{pc: pc_q, inst: ic_inst};

`ifdef FETCH_JAL_PREDICT_EN
    assign seq_pc = (ic_inst[6:0] == OPC_JAL) ? pc_q + fetch_jal_offset(ic_inst)
                                              : pc_q + 32'd4;
`else
    assign seq_pc = pc_q + 32'd4;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIssue;
            pc_q       <= RESET_PC;
            inflight_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = inflight_q;
        ic_send_pulse = 1'b0;
        fifo_push     = 1'b0;
        fifo_flush    = 1'b0;

        if (redirect_valid) begin
            pc_d       = redir_pc;
            fifo_flush = 1'b1;
        end

        case (state_q)
            StIssue: begin
                if (!redirect_valid && has_room && rst_n) begin
                    ic_send_pulse = 1'b1;
                    inflight_d    = pc_q;
                    state_d       = StWait;
                end
            end
            StWait: begin
                if (ic_ack) begin
                    state_d = StIssue;
                    if (!redirect_valid) begin
                        fifo_push = 1'b1;
                        pc_d      = seq_pc;
                    end
                end else if (redirect_valid) begin
                    state_d = StDrop;
                end
            end
            StDrop: begin
                if (ic_ack) begin
                    state_d = StIssue;
                end
            end
            default: state_d = StIssue;
        endcase
    end

    // While dropping, the cache still owns the old request address.
    assign ic_addr = (state_q == StDrop) ? inflight_q : pc_q;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign dec_valid = !fifo_empty;
    assign dec_inst  = fifo_head.inst;
    assign dec_pc    = fifo_head.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage: one vector per clock cycle plus a reset sequence.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] ic_addr;
    logic        ic_send_pulse;
    logic [31:0] ic_inst = '0;
    logic        ic_ack = 1'b0;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        dec_ready = 1'b0;

    always #5 clk = ~clk;

    fetch_stage u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ic_addr        (ic_addr),
        .ic_send_pulse  (ic_send_pulse),
        .ic_inst        (ic_inst),
        .ic_ack         (ic_ack),
        .dec_valid      (dec_valid),
        .dec_inst       (dec_inst),
        .dec_pc         (dec_pc),
        .dec_ready      (dec_ready)
    );

`ifdef FETCH_JAL_PREDICT_EN
    localparam logic [31:0] JalNext = 32'h0000_0020;
`else
    localparam logic [31:0] JalNext = 32'h0000_0014;
`endif

    typedef struct {
        bit          rst;
        bit          rv;
        logic [31:0] rpc;
        bit          ack;
        logic [31:0] inst;
        bit          rdy;
        bit          e_pulse;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] cx(input logic [31:0] a);
        return a ^ 32'hA5A5_A5A5;
    endfunction

    task automatic v(input bit rst, input bit rv, input logic [31:0] rpc, input bit ack,
                     input logic [31:0] inst, input bit rdy, input bit e_pulse,
                     input logic [31:0] e_addr, input bit e_valid, input logic [31:0] e_pc,
                     input logic [31:0] e_inst);
        vec_t t;
        t = '{rst, rv, rpc, ack, inst, rdy, e_pulse, e_addr, e_valid, e_pc, e_inst};
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic do_reset();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        ic_ack         = 1'b0;
        ic_inst        = '0;
        dec_ready      = 1'b0;
        rst_n          = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // A: hits, decode always ready
        v(1,0,0,0,0,1,         1,32'h0,0,0,0);
        v(0,0,0,1,cx(0),1,     0,32'h0,0,0,0);
        v(0,0,0,0,0,1,         1,32'h4,1,32'h0,cx(0));
        v(0,0,0,1,cx(4),1,     0,32'h4,0,0,0);
        v(0,0,0,0,0,1,         1,32'h8,1,32'h4,cx(4));
        v(0,0,0,1,cx(8),1,     0,32'h8,0,0,0);
        v(0,0,0,0,0,1,         1,32'hC,1,32'h8,cx(8));
        // B: decode stalled, buffer fills, then resumes
        v(1,0,0,0,0,0,         1,32'h0,0,0,0);
        v(0,0,0,1,cx(0),0,     0,32'h0,0,0,0);
        v(0,0,0,0,0,0,         1,32'h4,1,32'h0,cx(0));
        v(0,0,0,1,cx(4),0,     0,32'h4,1,32'h0,cx(0));
        v(0,0,0,0,0,0,         0,32'h8,1,32'h0,cx(0));
        v(0,0,0,0,0,0,         0,32'h8,1,32'h0,cx(0));
        v(0,0,0,0,0,1,         1,32'h8,1,32'h0,cx(0));
        v(0,0,0,0,0,1,         0,32'h8,1,32'h4,cx(4));
        v(0,0,0,1,cx(8),1,     0,32'h8,0,0,0);
        v(0,0,0,0,0,1,         1,32'hC,1,32'h8,cx(8));
        // C: miss, ack six cycles after the pulse
        v(1,0,0,0,0,1,         1,32'h0,0,0,0);
        for (int i = 0; i < 5; i++) v(0,0,0,0,0,1, 0,32'h0,0,0,0);
        v(0,0,0,1,cx(0),1,     0,32'h0,0,0,0);
        v(0,0,0,0,0,1,         1,32'h4,1,32'h0,cx(0));
        // D: redirect while addr 4 is outstanding, late ack dropped
        v(1,0,0,0,0,0,         1,32'h0,0,0,0);
        v(0,0,0,1,cx(0),0,     0,32'h0,0,0,0);
        v(0,0,0,0,0,0,         1,32'h4,1,32'h0,cx(0));
        v(0,0,0,0,0,0,         0,32'h4,1,32'h0,cx(0));
        v(0,1,32'h100,0,0,0,   0,32'h4,1,32'h0,cx(0));
        v(0,0,0,1,cx(4),0,     0,32'h4,0,0,0);
        v(0,0,0,0,0,0,         1,32'h100,0,0,0);
        v(0,0,0,1,cx(32'h100),0, 0,32'h100,0,0,0);
        v(0,0,0,0,0,0,         1,32'h104,1,32'h100,cx(32'h100));
        // E: redirect coincident with ack
        v(1,0,0,0,0,1,         1,32'h0,0,0,0);
        v(0,1,32'h200,1,cx(0),1, 0,32'h0,0,0,0);
        v(0,0,0,0,0,1,         1,32'h200,0,0,0);
        v(0,0,0,1,cx(32'h200),1, 0,32'h200,0,0,0);
        v(0,0,0,0,0,1,         1,32'h204,1,32'h200,cx(32'h200));
        // F: redirect in issue, low bits forced to zero, pc wraps
        v(1,1,32'hFFFF_FFFF,0,0,1, 0,32'h0,0,0,0);
        v(0,0,0,0,0,1,         1,32'hFFFF_FFFC,0,0,0);
        v(0,0,0,1,32'h13,1,    0,32'hFFFF_FFFC,0,0,0);
        v(0,0,0,0,0,1,         1,32'h0,1,32'hFFFF_FFFC,32'h13);
        // G: JAL at 0x10
        v(1,1,32'h10,0,0,1,    0,32'h0,0,0,0);
        v(0,0,0,0,0,1,         1,32'h10,0,0,0);
        v(0,0,0,1,32'h0100_006F,1, 0,32'h10,0,0,0);
        v(0,0,0,0,0,1,         1,JalNext,1,32'h10,32'h0100_006F);
        // H: repeated redirect while dropping
        v(1,0,0,0,0,1,         1,32'h0,0,0,0);
        v(0,1,32'h40,0,0,1,    0,32'h0,0,0,0);
        v(0,1,32'h80,0,0,1,    0,32'h0,0,0,0);
        v(0,0,0,1,cx(0),1,     0,32'h0,0,0,0);
        v(0,0,0,0,0,1,         1,32'h80,0,0,0);

        // Reset values while held in reset
        @(negedge clk);
        #1;
        chk("rst_pulse", 0, 32'(ic_send_pulse), 32'h0);
        chk("rst_addr",  0, ic_addr, 32'h0);
        chk("rst_valid", 0, 32'(dec_valid), 32'h0);
        chk("rst_pc",    0, dec_pc, 32'h0);
        chk("rst_inst",  0, dec_inst, 32'h0);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            ic_ack         = vecs[i].ack;
            ic_inst        = vecs[i].inst;
            dec_ready      = vecs[i].rdy;
            #1;
            chk("pulse", i, 32'(ic_send_pulse), 32'(vecs[i].e_pulse));
            chk("addr",  i, ic_addr, vecs[i].e_addr);
            chk("valid", i, 32'(dec_valid), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                chk("dec_pc",   i, dec_pc, vecs[i].e_pc);
                chk("dec_inst", i, dec_inst, vecs[i].e_inst);
            end
            @(negedge clk);
        end

        // Reset asserted while a request is outstanding and the buffer holds an entry
        do_reset();
        dec_ready = 1'b0;
        @(negedge clk);
        ic_ack  = 1'b1;
        ic_inst = cx(0);
        @(negedge clk);
        ic_ack = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_addr",  0, ic_addr, 32'h4);
        chk("mid_valid", 0, 32'(dec_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pulse", 0, 32'(ic_send_pulse), 32'h0);
        chk("mid_rst_addr",  0, ic_addr, 32'h0);
        chk("mid_rst_valid", 0, 32'(dec_valid), 32'h0);
        chk("mid_rst_pc",    0, dec_pc, 32'h0);
        chk("mid_rst_inst",  0, dec_inst, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_pulse", 0, 32'(ic_send_pulse), 32'h1);
        chk("post_rst_addr",  0, ic_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch front end sitting directly upstream of the instruction cache and downstream of the execute-stage redirect path. Holds the program counter, issues one-cycle request pulses with a stable address to the cache, captures the acknowledged instruction with its PC into a small FIFO, and presents entries to decode over a valid/ready handshake. Handles branch redirects by flushing buffered entries and discarding any response still in flight.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC fetched first after reset; bits [1:0] must be 0.
- `FIFO_DEPTH`, default `2`: decode-buffer entries; power of two, ≥2.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `redirect_valid` in 1: one-cycle redirect request from execute.
- `redirect_pc` in 32: redirect target; bits [1:0] ignored and forced to 0.
- `ic_addr` out 32: fetch address to cache; held stable from pulse until ack.
- `ic_send_pulse` out 1: single-cycle request strobe to cache.
- `ic_inst` in 32: instruction from cache; valid only when `ic_ack`=1.
- `ic_ack` in 1: cache response strobe; one cycle per request.
- `dec_valid` out 1: FIFO head valid.
- `dec_inst` out 32: head instruction.
- `dec_pc` out 32: head PC.
- `dec_ready` in 1: decode accepts head this cycle.

## Operation
- Registered FSM, states `ISSUE`, `WAIT`, `DROP`.
- `ISSUE`: if no redirect and `count < FIFO_DEPTH` (count includes no in-flight since only one request outstanding), assert `ic_send_pulse`=1 for one cycle with `ic_addr`=pc, go `WAIT`. Otherwise stay, pulse 0.
- `WAIT`: `ic_addr`=pc held. On `ic_ack` without redirect: push {pc, `ic_inst`}, pc←pc+4, go `ISSUE`.
- Redirect in `ISSUE`: pc←redirect_pc, flush FIFO, no pulse that cycle, stay `ISSUE`.
- Redirect in `WAIT` without `ic_ack`: pc←redirect_pc, flush, go `DROP`.
- Redirect in `WAIT` or `DROP` with `ic_ack` same cycle: response discarded, pc←redirect_pc, flush, go `ISSUE`.
- `DROP`: `ic_addr` keeps old in-flight address until ack; on `ic_ack` discard data, go `ISSUE`; `ic_addr` switches to pc next cycle.
- Redirect in `DROP` without ack: pc updated, flush, stay `DROP`.
- FIFO: `dec_valid`=!empty; pop on `dec_valid && dec_ready`. Push and pop same cycle allowed, count unchanged. Flush overrides push and pop.
- Issue check counts the entry about to be pushed: pulse only if `count + pop_this_cycle` leaves room; never overflow.
- pc arithmetic modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values: `ic_send_pulse`=0, `ic_addr`=`RESET_PC`, `dec_valid`=0, `dec_inst`=0, `dec_pc`=0, state `ISSUE`, pc=`RESET_PC`, FIFO empty.
- First pulse in first clock edge cycle after `rst_n` deasserts.
- Cache hit acks one cycle after pulse; peak rate one fetch per 2 cycles. Miss latency unbounded; stage waits.
- Pushed entry visible on `dec_*` the cycle after ack (ack at cycle t → `dec_valid`=1 at t+1 if FIFO was empty).
- Next pulse earliest the cycle after ack.
- `rst_n` assertion mid-request: all state cleared immediately; cache is reset by the same reset, no ack awaited.

## Configuration
- `FETCH_JAL_PREDICT_EN` defined: on accepted ack with `ic_inst[6:0]`=7'b1101111, pc←pc+sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}) instead of pc+4; entry still pushed. Redirects take priority.
- Not defined: next pc is always pc+4 or redirect_pc.

## Structure
- `fetch_pkg`: `fetch_state_t` enum, `fetch_entry_t` struct {pc[31:0], inst[31:0]}, `OPC_JAL` constant.
- One sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t`, parameter `DEPTH`, push/pop/flush, count output, async active-low reset.

## Test plan
- Reset, cache acks 1 cycle after each pulse with inst=addr^32'hA5A5_A5A5, dec_ready=1 -> pulses at addr 0,4,8 every 2 cycles; dec_pc 0,4,8 in order with matching inst.
- dec_ready=0, hits -> exactly 2 entries (pc 0,4) buffered, no third pulse; raise dec_ready -> fetch of 8 resumes.
- Miss: ack 6 cycles after pulse -> ic_addr held at 0 all 6 cycles, single pulse, dec_valid one cycle after ack.
- Redirect to 32'h100 two cycles after pulse for addr 4 (ack at cycle 5) -> FIFO flushed, ack data dropped, next pulse addr 32'h100, no pc 4 entry at decode.
- Redirect to 32'h200 coincident with ack -> data dropped, next pulse 32'h200 the following cycle.
- With `FETCH_JAL_PREDICT_EN`, inst 32'h0100_006F at pc 0x10 -> next pulse addr 0x20; without macro -> 0x14.
